bb_uart_rx: RTL
===============

# bb_uart_rx

UART receiver for the ispMACH 4256ZE breakout board: it is the receive-side counterpart of the board's UART transmitter, deserialising the 8N1 stream arriving from the PC (RS232 level shifter or USB serial cable) into bytes. It oversamples `rxd` with `bdclk` and validates the start bit. Each data bit is sampled at mid-bit. Completed bytes are presented on `rxreg`, with a ready/acknowledge handshake to the consuming logic, plus framing and overrun flags.

## Interface
- `OVERSAMPLE`, 16: `bdclk` cycles per bit. Must be even and ≥4; `bdclk` = `OVERSAMPLE` × baud (9600 Bd → 153600 Hz).
- `bdclk` input 1: oversampling clock, the only clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rxd` input 1: serial receive data, asynchronous; idle = 1.
- `rxack` input 1: consumer acknowledges the byte in `rxreg`; clears `rxrdy` and `rxovr`.
- `rxreg` output 8: last correctly framed byte received.
- `rxrdy` output 1: `rxreg` holds an unacknowledged byte.
- `rxbsy` output 1: a frame is in progress (state ≠ IDLE).
- `rxerr` output 1: framing error, a one-cycle pulse.
- `rxovr` output 1: overrun, sticky until `rxack`.

## Operation
- Input synchroniser:
  - `rxd` passes through 2 flops to give `rxs`; all decisions use `rxs`.
  - Both flops reset to 1.
- Bit counter `cnt`:
  - Width ⌈log2 OVERSAMPLE⌉.
  - Cleared on every state entry.
- Bit index `bitn`: 0..7. Shift register `sh`: 8 bits.
- **IDLE**: when `rxs`=0, go to START with `cnt`=0.
- **START**:
  - `cnt` increments each cycle.
  - At `cnt`=OVERSAMPLE/2−1, sample `rxs`:
    - `rxs`=0: go to DATA, `cnt`=0, `bitn`=0.
    - `rxs`=1: treat as a glitch and return to IDLE. No flag.
- **DATA**:
  - At `cnt`=OVERSAMPLE−1, sample `rxs` into `sh` LSB-first: `sh` <= {`rxs`, `sh[7:1]`}.
  - Then set `cnt`=0.
  - On the 8th sample (`bitn`=7), go to STOP; otherwise `bitn`+1.
- **STOP**: at `cnt`=OVERSAMPLE−1, sample `rxs`:
  - `rxs`=1, valid frame:
    - If `rxrdy`=0, or `rxack`=1 in the same cycle: `rxreg` <= `sh`, `rxrdy` <= 1.
    - Else: byte dropped, `rxreg` unchanged, `rxovr` <= 1.
    - Go to IDLE.
  - `rxs`=0, framing error (includes break):
    - `rxerr` pulses for 1 cycle; `rxreg`/`rxrdy` unchanged.
    - Go to BREAK.
- **BREAK**: wait until `rxs`=1, then go to IDLE. This prevents a held-low line from restarting frames.
- Handshake:
  - `rxack` with `rxrdy`=1 clears `rxrdy` and `rxovr` at the next edge.
  - `rxack` with `rxrdy`=0 is ignored.
  - A byte load in the same cycle as `rxack` takes priority, so `rxrdy` stays 1 and `rxovr` is cleared.
- Reset mid-frame:
  - Abandons the frame.
  - State returns to IDLE; `rxreg`, `rxrdy`, `rxerr`, `rxovr` and `rxbsy` are cleared.
  - The synchroniser is set to 1 and `sh`, `cnt`, `bitn` to 0.

## Timing
- Reset values: `rxreg`=8'h00, `rxrdy`=0, `rxbsy`=0, `rxerr`=0, `rxovr`=0.
- All outputs are registered.
- `rxbsy` rises the cycle after IDLE→START is taken and falls when IDLE is re-entered.
- Latencies, with t0 = the first `bdclk` edge at which `rxd`=0 is captured by the first synchroniser flop:
  - START entered at t0+2.
  - Start sample at t0+2+OVERSAMPLE/2.
  - Data bit k sampled at t0+2+OVERSAMPLE/2+(k+1)·OVERSAMPLE.
  - Stop sample at t0+2+OVERSAMPLE/2+9·OVERSAMPLE.
  - `rxrdy`/`rxreg` (or `rxerr`) valid on the following cycle.
- Minimum 0-length idle between frames: a new start edge is accepted from the first cycle of IDLE after the stop sample, so back-to-back frames are received.
- Baud tolerance: sampling at mid-bit tolerates ±4% cumulative clock mismatch for OVERSAMPLE=16.

## Test plan
- Reset, then apply 0x55 at 9600 Bd (OVERSAMPLE=16), 8N1 → `rxreg`=0x55 and `rxrdy`=1 one cycle after the stop sample. `rxerr`=0, `rxovr`=0. After `rxack`, `rxrdy`=0 next cycle.
- Two back-to-back frames 0xA3, 0x0F with `rxack` issued between them → 0xA3 then 0x0F, each raising `rxrdy`. No overrun.
- Frame 0x3C with the stop bit forced to 0, then line held low for 20 bit times → `rxerr` single-cycle pulse, `rxreg` keeps its prior value. Module stays in BREAK with `rxbsy`=1 until the line rises, then frame 0x81 is received correctly.
- 0x12 received without acknowledge, then 0x34 → `rxreg` stays 0x12 and `rxovr`=1. `rxack` clears both `rxrdy` and `rxovr`. A second scenario asserts `rxack` exactly in the 0x34 load cycle → `rxreg`=0x34, `rxrdy`=1, `rxovr`=0.
- 0-pulse of 5 `bdclk` cycles on idle line → return to IDLE with no `rxrdy` and no `rxerr`; `rxbsy` high for at most OVERSAMPLE/2+1 cycles.
- `rst` asserted mid-frame during bit 4 of 0xF0 → next cycle all outputs at reset values. A subsequent clean 0x6B is received correctly.

Source files
------------

// File: rtl/bb_uart_rx_if.sv
// Receive-side byte handshake between bb_uart_rx and the consuming logic.
// master = receiver (drives byte/status), slave = consumer (drives acknowledge).
interface bb_uart_rx_if;
   logic       rxack;
   logic [7:0] rxreg;
   logic       rxrdy;
   logic       rxbsy;
   logic       rxerr;
   logic       rxovr;

   modport master (
      input  rxack,
      output rxreg,
      output rxrdy,
      output rxbsy,
      output rxerr,
      output rxovr
   );

   modport slave (
      output rxack,
      input  rxreg,
      input  rxrdy,
      input  rxbsy,
      input  rxerr,
      input  rxovr
   );
endinterface

// File: rtl/bb_uart_rx.sv
// 8N1 UART receiver: oversampled start-bit validation, mid-bit data sampling,
// byte handoff with ready/ack plus framing-error pulse and sticky overrun.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for rxs=0
// S_START | counting to mid start bit; rxs=1 there is a glitch
// S_DATA  | sampling 8 data bits LSB-first, one per OVERSAMPLE cycles
// S_STOP  | sampling stop bit; 1 = deliver/overrun, 0 = framing error
// S_BREAK | line held low after a framing error; wait for rxs=1
module bb_uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic         i_bdclk,
   input  logic         i_rst,
   input  logic         i_rxd,
   bb_uart_rx_if.master bus
);

   localparam int W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [W-1:0] C_HALF = W'(OVERSAMPLE / 2 - 1);
   localparam logic [W-1:0] C_LAST = W'(OVERSAMPLE - 1);
   localparam logic [W-1:0] C_ONE  = W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic         r_sync1;
   logic         r_sync2;
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;
   logic [2:0]   r_bitn;
   logic [2:0]   w_bitn_nxt;
   logic [7:0]   r_sh;
   logic [7:0]   w_sh_nxt;
   logic         w_load;
   logic         w_drop;
   logic         w_ferr;
   logic [7:0]   r_rxreg;
   logic         r_rxrdy;
   logic         r_rxbsy;
   logic         r_rxerr;
   logic         r_rxovr;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + C_ONE;
      w_bitn_nxt  = r_bitn;
      w_sh_nxt    = r_sh;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!r_sync2) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_cnt == C_HALF) begin
               w_cnt_nxt = '0;
               if (r_sync2) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_DATA;
                  w_bitn_nxt  = 3'd0;
               end
            end
         end
         S_DATA: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt = '0;
               w_sh_nxt  = {r_sync2, r_sh[7:1]};
               if (r_bitn == 3'd7) w_state_nxt = S_STOP;
               else                w_bitn_nxt  = r_bitn + 3'd1;
            end
         end
         S_STOP: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt = '0;
               if (r_sync2) begin
                  w_state_nxt = S_IDLE;
                  // an ack landing on the load edge frees rxreg in time
                  if (!r_rxrdy || bus.rxack) w_load = 1'b1;
                  else                       w_drop = 1'b1;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_cnt_nxt = '0;
            if (r_sync2) w_state_nxt = S_IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_bdclk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_cnt   <= '0;
         r_bitn  <= 3'd0;
         r_sh    <= 8'h00;
         r_rxreg <= 8'h00;
         r_rxrdy <= 1'b0;
         r_rxbsy <= 1'b0;
         r_rxerr <= 1'b0;
         r_rxovr <= 1'b0;
      end else begin
         r_sync1 <= i_rxd;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bitn  <= w_bitn_nxt;
         r_sh    <= w_sh_nxt;
         r_rxbsy <= (w_state_nxt != S_IDLE);
         r_rxerr <= w_ferr;
         if (bus.rxack && r_rxrdy) begin
            r_rxrdy <= 1'b0;
            r_rxovr <= 1'b0;
         end
         if (w_load) begin
            r_rxreg <= r_sh;
            r_rxrdy <= 1'b1;
         end
         if (w_drop) r_rxovr <= 1'b1;
      end
   end

   assign bus.rxreg = r_rxreg;
   assign bus.rxrdy = r_rxrdy;
   assign bus.rxbsy = r_rxbsy;
   assign bus.rxerr = r_rxerr;
   assign bus.rxovr = r_rxovr;

endmodule
